// File: rtl/lut_neuron_bank_pkg.sv
// Shared types and helpers for the runtime-loadable LUT neuron bank.
package lut_bank_pkg;

  // Bank lifecycle: no table yet, load session in progress, serving lookups.
  typedef enum logic [1:0] {
    UNLOADED = 2'd0,
    LOADING  = 2'd1,
    READY    = 2'd2
  } state_t;

  // Bit offset of neuron n's slice inside a packed per-neuron vector.
  function automatic int sliceOffset(input int neuron, input int width);
    return neuron * width;
  endfunction

endpackage

// File: rtl/lut_neuron_bank_if.sv
// Config, input-stream and output-stream signals of the LUT neuron bank.
interface lut_neuron_bank_if #(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 4,
  parameter int NIDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
);

  logic                         cfg_valid;
  logic                         cfg_ready;
  logic [NIDX_W-1:0]            cfg_neuron;
  logic [FAN_IN-1:0]            cfg_addr;
  logic [OUT_BITS-1:0]          cfg_data;
  logic                         cfg_last;

  logic                         in_valid;
  logic                         in_ready;
  logic [NEURONS*FAN_IN-1:0]    in_data;

  logic                         out_valid;
  logic                         out_ready;
  logic [NEURONS*OUT_BITS-1:0]  out_data;

  logic                         loaded;
  logic                         cfg_err;

  // Upstream side: drives config writes and input vectors, consumes results.
  modport master (
    output cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last,
    output in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, loaded, cfg_err
  );

  // The neuron bank itself.
  modport slave (
    input  cfg_valid, cfg_neuron, cfg_addr, cfg_data, cfg_last,
    input  in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, loaded, cfg_err
  );

endinterface

// File: rtl/lut_neuron_ram.sv
// One neuron's truth table: 2**FAN_IN x OUT_BITS distributed RAM,
// synchronous write, asynchronous read. Contents are deliberately not reset.
module lut_neuron_ram #(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [FAN_IN-1:0]   i_waddr,
  input  logic [OUT_BITS-1:0] i_wdata,
  input  logic [FAN_IN-1:0]   i_raddr,
  output logic [OUT_BITS-1:0] o_rdata
);

  logic [OUT_BITS-1:0] r_mem [2**FAN_IN];

  // Table entry update on an accepted config write.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lut_neuron_bank.sv
// Bank of NEURONS runtime-loadable LUT neurons with a config port and a
// single registered valid/ready inference stage.
module lut_neuron_bank
  import lut_bank_pkg::*;
#(
  parameter int FAN_IN   = 6,
  parameter int OUT_BITS = 1,
  parameter int NEURONS  = 4,
  parameter int NIDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input logic              clk,
  input logic              rst,
  lut_neuron_bank_if.slave bus
);

  localparam logic [NIDX_W:0] NEURON_LIMIT = (NIDX_W + 1)'(NEURONS);

  state_t                         r_state;
  state_t                         w_nextState;
  logic                           r_outValid;
  logic [NEURONS*OUT_BITS-1:0]    r_outData;
  logic                           r_loaded;
  logic                           r_cfgErr;
  logic [NEURONS*OUT_BITS-1:0]    w_lookup;
  logic                           w_cfgReady;
  logic                           w_inReady;
  logic                           w_cfgFire;
  logic                           w_inFire;
  logic                           w_badIdx;

  assign w_badIdx = ({1'b0, bus.cfg_neuron} >= NEURON_LIMIT);

  // Handshake readiness and next state; inference wins over config in READY.
  always_comb begin
    w_nextState = r_state;
    w_cfgReady  = 1'b0;
    w_inReady   = 1'b0;
    if (!rst) begin
      case (r_state)
        UNLOADED, LOADING: begin
          w_cfgReady = 1'b1;
        end
        READY: begin
          w_inReady  = !r_outValid || bus.out_ready;
          w_cfgReady = !r_outValid && !bus.in_valid;
        end
        default: begin
          w_nextState = UNLOADED;
        end
      endcase
    end
    w_cfgFire = bus.cfg_valid && w_cfgReady;
    w_inFire  = bus.in_valid && w_inReady;
    if (w_cfgFire) begin
      w_nextState = bus.cfg_last ? READY : LOADING;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOADED;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Sticky status: a load session has completed, an out-of-range write was seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loaded <= 1'b0;
      r_cfgErr <= 1'b0;
    end else begin
      if (w_cfgFire && bus.cfg_last) begin
        r_loaded <= 1'b1;
      end
      if (w_cfgFire && w_badIdx) begin
        r_cfgErr <= 1'b1;
      end
    end
  end

  // Output stage: reload on accepted input, clear when consumed, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
    end else if (w_inFire) begin
      r_outValid <= 1'b1;
      r_outData  <= w_lookup;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    logic w_we;
    assign w_we = w_cfgFire && (bus.cfg_neuron == NIDX_W'(n));
    lut_neuron_ram #(
      .FAN_IN   (FAN_IN),
      .OUT_BITS (OUT_BITS)
    ) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (bus.cfg_addr),
      .i_wdata (bus.cfg_data),
      .i_raddr (bus.in_data[sliceOffset(n, FAN_IN) +: FAN_IN]),
      .o_rdata (w_lookup[sliceOffset(n, OUT_BITS) +: OUT_BITS])
    );
  end

  assign bus.cfg_ready = w_cfgReady;
  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.loaded    = r_loaded;
  assign bus.cfg_err   = r_cfgErr;

endmodule

// File: tb/tb_lut_neuron_bank.sv
// Directed self-checking bench for lut_neuron_bank: a 4-neuron bank for the
// main flow and a 3-neuron bank for out-of-range config writes.
module tb_lut_neuron_bank;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lut_neuron_bank_if #(.FAN_IN(6), .OUT_BITS(1), .NEURONS(4), .NIDX_W(2)) bus ();
  lut_neuron_bank_if #(.FAN_IN(6), .OUT_BITS(1), .NEURONS(3), .NIDX_W(2)) busSmall ();

  lut_neuron_bank #(.FAN_IN(6), .OUT_BITS(1), .NEURONS(4), .NIDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  lut_neuron_bank #(.FAN_IN(6), .OUT_BITS(1), .NEURONS(3), .NIDX_W(2)) dutSmall (
    .clk (clk),
    .rst (rst),
    .bus (busSmall.slave)
  );

  int   nVectors = 0;
  int   nMiscompares = 0;
  logic expTable [4][64];

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nVectors++;
    if (observed !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-neuron input pattern p, skewed so the neurons see different entries.
  function automatic logic [23:0] vecOf(input int p);
    logic [23:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) begin
      v[n*6 +: 6] = 6'((p + 17 * n) % 64);
    end
    return v;
  endfunction

  function automatic logic [3:0] expOut(input logic [23:0] v);
    logic [3:0] r;
    for (int n = 0; n < 4; n++) begin
      r[n] = expTable[n][v[n*6 +: 6]];
    end
    return r;
  endfunction

  // Config write on the main bank; waits (bounded) for cfg_ready.
  task automatic cfgWrite(input logic [1:0] n, input logic [5:0] a,
                          input logic d, input logic last);
    int waitCycles = 0;
    bus.cfg_valid  = 1'b1;
    bus.cfg_neuron = n;
    bus.cfg_addr   = a;
    bus.cfg_data   = d;
    bus.cfg_last   = last;
    @(negedge clk);
    while (!bus.cfg_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!bus.cfg_ready) checkOutput("cfgHandshake", 32'(bus.cfg_ready), 32'd1);
    else expTable[n][a] = d;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
  endtask

  // Config write on the 3-neuron bank; waits (bounded) for cfg_ready.
  task automatic cfgWriteSmall(input logic [1:0] n, input logic [5:0] a,
                               input logic d, input logic last);
    int waitCycles = 0;
    busSmall.cfg_valid  = 1'b1;
    busSmall.cfg_neuron = n;
    busSmall.cfg_addr   = a;
    busSmall.cfg_data   = d;
    busSmall.cfg_last   = last;
    @(negedge clk);
    while (!busSmall.cfg_ready && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!busSmall.cfg_ready) checkOutput("smallCfgHandshake", 32'(busSmall.cfg_ready), 32'd1);
    tick();
    busSmall.cfg_valid = 1'b0;
    busSmall.cfg_last  = 1'b0;
  endtask

  // One lookup on the main bank with a hand-computed result.
  task automatic applyStimulus(input string tag, input logic [23:0] v, input logic [3:0] expected);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "Valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "Data"}, 32'(bus.out_data), 32'(expected));
    tick();
  endtask

  // One lookup on the 3-neuron bank.
  task automatic applyStimulusSmall(input string tag, input logic [17:0] v, input logic [2:0] expected);
    busSmall.in_valid = 1'b1;
    busSmall.in_data  = v;
    tick();
    busSmall.in_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "Valid"}, 32'(busSmall.out_valid), 32'd1);
    checkOutput({tag, "Data"}, 32'(busSmall.out_data), 32'(expected));
    tick();
  endtask

  initial begin
    logic [5:0] av;
    logic [23:0] vA, vB, vC;

    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_neuron = '0; bus.cfg_addr = '0;
    bus.cfg_data = '0; bus.cfg_last = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = '0; bus.out_ready = 1'b1;
    busSmall.cfg_valid = 1'b0; busSmall.cfg_neuron = '0; busSmall.cfg_addr = '0;
    busSmall.cfg_data = '0; busSmall.cfg_last = 1'b0;
    busSmall.in_valid = 1'b0; busSmall.in_data = '0; busSmall.out_ready = 1'b1;

    // Reset values, with an input already offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("rstCfgReady", 32'(bus.cfg_ready), 32'd0);
    checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstOutData", 32'(bus.out_data), 32'd0);
    checkOutput("rstLoaded", 32'(bus.loaded), 32'd0);
    checkOutput("rstCfgErr", 32'(bus.cfg_err), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("unloadedInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("unloadedCfgReady", 32'(bus.cfg_ready), 32'd1);
    checkOutput("unloadedOutValid", 32'(bus.out_valid), 32'd0);
    tick();

    // Full table load with in_valid held high; inference must stay gated.
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 64; a++) begin
        av = 6'(a);
        cfgWrite(2'(n), av, (n == 0) ? (av[5] ^ av[2]) : 1'b1, (n == 3) && (a == 63));
        if (n == 0 && a == 5) begin
          @(negedge clk);
          checkOutput("loadingInReady", 32'(bus.in_ready), 32'd0);
          checkOutput("loadingOutValid", 32'(bus.out_valid), 32'd0);
          checkOutput("loadingLoaded", 32'(bus.loaded), 32'd0);
          tick();
        end
      end
    end
    @(negedge clk);
    checkOutput("loadedFlag", 32'(bus.loaded), 32'd1);
    checkOutput("loadedInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("loadedOutValid", 32'(bus.out_valid), 32'd0);
    bus.in_valid = 1'b0;
    tick();

    // Stream all 64 patterns back to back; result k appears one cycle later.
    for (int p = 0; p <= 64; p++) begin
      bus.in_valid = (p < 64);
      bus.in_data  = vecOf(p % 64);
      @(negedge clk);
      if (p > 0) begin
        checkOutput("streamValid", 32'(bus.out_valid), 32'd1);
        checkOutput("streamData", 32'(bus.out_data), 32'(expOut(vecOf(p - 1))));
      end
      tick();
    end
    @(negedge clk);
    checkOutput("streamDrained", 32'(bus.out_valid), 32'd0);
    tick();

    // Hand-computed lookups: neuron0 = x[5]^x[2], others all ones.
    applyStimulus("hand100000", {4{6'b100000}}, 4'b1111);
    applyStimulus("hand100100", {4{6'b100100}}, 4'b1110);
    applyStimulus("hand000100", {4{6'b000100}}, 4'b1111);
    applyStimulus("hand000001", {18'd0, 6'b000001}, 4'b1110);

    // Backpressure: A held for 5 stalled cycles while B waits, then B, C.
    vA = {4{6'b100100}};
    vB = {4{6'b100000}};
    vC = {18'd0, 6'b000001};
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = vA;
    tick();
    bus.in_data = vB;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stallValid", 32'(bus.out_valid), 32'd1);
      checkOutput("stallData", 32'(bus.out_data), 32'h0000000e);
      checkOutput("stallInReady", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("releaseInReady", 32'(bus.in_ready), 32'd1);
    checkOutput("releaseHoldData", 32'(bus.out_data), 32'h0000000e);
    tick();
    bus.in_data = vC;
    @(negedge clk);
    checkOutput("resumeB", 32'(bus.out_data), 32'h0000000f);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("resumeCValid", 32'(bus.out_valid), 32'd1);
    checkOutput("resumeC", 32'(bus.out_data), 32'h0000000e);
    tick();
    @(negedge clk);
    checkOutput("resumeDrained", 32'(bus.out_valid), 32'd0);
    tick();

    // Reload priority: config waits while an input is offered or a result is pending.
    bus.cfg_valid  = 1'b1;
    bus.cfg_neuron = 2'd0;
    bus.cfg_addr   = 6'd0;
    bus.cfg_data   = 1'b1;
    bus.cfg_last   = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_data    = 24'd0;
    @(negedge clk);
    checkOutput("prioCfgReadyIn", 32'(bus.cfg_ready), 32'd0);
    checkOutput("prioInReady", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("prioCfgReadyOut", 32'(bus.cfg_ready), 32'd0);
    checkOutput("prioOldLookup", 32'(bus.out_data), 32'h0000000e);
    tick();
    @(negedge clk);
    checkOutput("prioCfgReadyDrained", 32'(bus.cfg_ready), 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    expTable[0][0] = 1'b1;
    applyStimulus("reloadLookup", 24'd0, 4'b1111);

    // A non-final write in READY reopens a load session and gates inference.
    cfgWrite(2'd1, 6'd0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("reopenInReady", 32'(bus.in_ready), 32'd0);
    tick();
    cfgWrite(2'd1, 6'd0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("reclosedInReady", 32'(bus.in_ready), 32'd1);
    tick();

    // Reset while a result is pending discards it.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = {4{6'b100000}};
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pendingValid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstDiscardValid", 32'(bus.out_valid), 32'd0);
    checkOutput("rstDiscardData", 32'(bus.out_data), 32'd0);
    checkOutput("rstDiscardLoaded", 32'(bus.loaded), 32'd0);
    tick();

    // Reset after 10 of 64 writes of a new session.
    bus.in_valid = 1'b1;
    for (int a = 0; a < 10; a++) begin
      cfgWrite(2'd0, 6'(a), expTable[0][a], 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midLoadLoaded", 32'(bus.loaded), 32'd0);
    checkOutput("midLoadInReady", 32'(bus.in_ready), 32'd0);
    checkOutput("midLoadOutValid", 32'(bus.out_valid), 32'd0);
    checkOutput("midLoadCfgReady", 32'(bus.cfg_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();

    // 3-neuron bank: every table is x[0]^x[1]; then an out-of-range write.
    for (int n = 0; n < 3; n++) begin
      for (int a = 0; a < 64; a++) begin
        av = 6'(a);
        cfgWriteSmall(2'(n), av, av[0] ^ av[1], (n == 2) && (a == 63));
      end
    end
    @(negedge clk);
    checkOutput("smallLoaded", 32'(busSmall.loaded), 32'd1);
    checkOutput("smallErrClear", 32'(busSmall.cfg_err), 32'd0);
    tick();
    applyStimulusSmall("smallX5", {3{6'd5}}, 3'b111);
    applyStimulusSmall("smallX3", {3{6'd3}}, 3'b000);
    cfgWriteSmall(2'd3, 6'd5, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("badIdxErr", 32'(busSmall.cfg_err), 32'd1);
    checkOutput("badIdxInReady", 32'(busSmall.in_ready), 32'd1);
    tick();
    applyStimulusSmall("badIdxUntouched", {3{6'd5}}, 3'b111);
    cfgWriteSmall(2'd2, 6'd63, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("badIdxSticky", 32'(busSmall.cfg_err), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("badIdxClearedByRst", 32'(busSmall.cfg_err), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/lut_neuron_bank.md
Name: lut_neuron_bank

Overview:
- Parametrised successor to the single fixed-table LUT neuron: a bank of NEURONS truth-table neurons.
- Each neuron has FAN_IN inputs and OUT_BITS outputs, with table contents loaded at runtime over a config port rather than baked in.
- Inference is streamed through a registered valid/ready stage.
- Sits between layer input fan-out wiring and the next layer, so one bitstream can host retrained networks.

Parameters:
- FAN_IN, 6, input bits per neuron; table depth is 2**FAN_IN.
- OUT_BITS, 1, output bits per neuron.
- NEURONS, 4, neurons in the bank.
- NIDX_W, $clog2(NEURONS) (minimum 1), neuron index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_neuron  in  NIDX_W  target neuron.
- cfg_addr  in  FAN_IN  table entry index.
- cfg_data  in  OUT_BITS  entry value.
- cfg_last  in  1  final write of a load session.
- in_valid  in  1  input vector valid.
- in_ready  out  1  input accepted when high with in_valid.
- in_data  in  NEURONS*FAN_IN  neuron n uses bits [n*FAN_IN +: FAN_IN].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  NEURONS*OUT_BITS  neuron n result at [n*OUT_BITS +: OUT_BITS].
- loaded  out  1  at least one complete load session finished.
- cfg_err  out  1  sticky: a write targeted cfg_neuron >= NEURONS.

Behaviour:
- Reset values (while rst is high and the cycle after): state UNLOADED, out_valid=0, out_data=0, loaded=0, cfg_err=0.
  - in_ready and cfg_ready are 0 while rst is high.
  - Table storage is not reset; it is distributed RAM.
- States:
  - UNLOADED:
    - cfg_ready=1, in_ready=0.
    - An accepted write moves to LOADING, or to READY if cfg_last=1.
  - LOADING:
    - cfg_ready=1, in_ready=0.
    - An accepted write with cfg_last=1 moves to READY and sets loaded=1.
  - READY:
    - in_ready = !out_valid || out_ready.
    - cfg_ready = !out_valid && !in_valid, so the pipeline must be drained and no input offered; inference has priority over config.
    - An accepted write without cfg_last moves to LOADING.
    - An accepted write with cfg_last stays READY.
- Config write: the entry is written on the accepting clock edge and is visible to lookups from the next cycle.
  - cfg_neuron >= NEURONS: the write is dropped, the handshake still completes, and cfg_err is set (sticky until rst).
- Inference: an input accepted at edge t produces out_valid=1 at t+1.
  - out_data holds the table lookup using the table as of edge t.
  - Throughput is 1 vector/cycle while out_ready=1.
- Output hold: while out_valid=1 and out_ready=0, out_data and out_valid stay stable and in_ready=0.
- Simultaneous out_ready=1 and accepted input: the output register reloads in the same cycle with no bubble.
- Lookup into a never-written entry returns undefined data. Verification must load full tables before checking.
- Reset mid-load: returns to UNLOADED and loaded=0. Previously written table entries persist but must be reloaded.
- Reset with out_valid=1: the result is discarded and out_valid=0 next cycle.

Decomposition:
- Shared package lut_bank_pkg:
  - state enum {UNLOADED, LOADING, READY}.
  - Helper function for the neuron slice offset.
- Sub-module lut_neuron_ram:
  - One 2**FAN_IN x OUT_BITS distributed RAM.
  - Synchronous write, asynchronous read.
  - Instantiated NEURONS times via generate.
- The top level holds the FSM, handshakes and output register.

Test Plan:
- Load gating: after reset, drive in_valid=1 -> in_ready=0, out_valid stays 0 until a cfg_last write is accepted; then loaded=1 and in_ready=1.
- Table load and check: load neuron0 with table(x)=x[5]^x[2], neuron1..3 with all-ones; stream all 64 patterns on every neuron, out_ready=1 -> out_data matches per neuron, one result per cycle, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out_data stable, in_ready=0, no vector lost or duplicated; release -> ordered results resume.
- Reload priority: in READY, offer cfg_valid together with in_valid=1 -> cfg_ready=0. Drop in_valid and drain -> writes accepted; the next lookup reflects the new entry.
- Bad index, with NEURONS=3: write cfg_neuron=3 -> handshake completes, cfg_err=1 and stays set, no neuron table changes.
- Reset mid-load: assert rst after 10 of 64 writes -> state UNLOADED, loaded=0, in_ready=0, out_valid=0 next cycle.
